fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the IF/ID pipeline register and replaces the bare PC register, PC+4 adder and PC mux. It owns the fetch PC and issues one-outstanding-request fetches to a multi-cycle instruction memory over a req/ack handshake. Returned words are buffered in a small queue of {pc, instr} entries and presented to IF/ID with a valid flag. It honours back-pressure from the hazard unit and flushes on branch redirects from ID.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with single-outstanding imem requests and a {pc, instr} queue
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   stall_i                        IF/ID not accepting; head entry is held
//   redirect_i, redirect_pc_i      branch redirect from ID; flush and refetch from target
//   imem_req_o, imem_addr_o        registered fetch request and address
//   imem_ack_i, imem_data_i        request completion and returned word
//   instr_valid_o, instr_o, pc_o   head of the fetch queue toward IF/ID

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_DROP = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_mem_q    [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];

  logic ack;
  logic valid;
  logic pop;
  logic push_en;
  logic outstanding_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    ack   = req_q & imem_ack_i;
    valid = (count_q != '0);
    // A redirect flushes the queue regardless of stall, so it suppresses pop and push.
    pop     = valid & ~stall_i & ~redirect_i;
    push_en = (state_q == S_RUN) & ack & ~redirect_i;

    case (state_q)
      S_RUN:  if (redirect_i && req_q && !imem_ack_i) state_d = S_DROP;
      S_DROP: if (ack) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    if (redirect_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc_i & ~32'h0000_0003;
    end else begin
      if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop);
    end

    // Reserve a queue slot for every in-flight request so a push can never hit a full queue.
    outstanding_d = req_q & ~imem_ack_i;
    if (!outstanding_d) begin
      if (count_d < CNT_W'(DEPTH)) begin
        req_d      = 1'b1;
        addr_d     = fetch_pc_d;
        fetch_pc_d = fetch_pc_d + 32'd4;
      end else begin
        req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset; entries are only visible while count_q covers them.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_en) begin
      pc_mem_q[wr_ptr_q]    <= addr_q;
      instr_mem_q[wr_ptr_q] <= imem_data_i;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid;
  assign instr_o       = valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  assign pc_o          = valid ? pc_mem_q[rd_ptr_q] : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

  localparam logic [31:0] C = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1 = 1'b1, stall1 = 1'b0, redir1 = 1'b0;
  logic [31:0] rpc1 = '0;
  logic        req1, ack1 = 1'b0, valid1;
  logic [31:0] addr1, data1 = '0, instr1, pc1;

  logic        rst2 = 1'b1, stall2 = 1'b0, redir2 = 1'b0;
  logic [31:0] rpc2 = '0;
  logic        req2, ack2 = 1'b0, valid2;
  logic [31:0] addr2, data2 = '0, instr2, pc2;

  int n_cmp = 0;
  int n_bad = 0;
  int wait_n = 0;
  int wcnt = 0;

  fetch_unit dut1 (
    .clk_i(clk), .rst_i(rst1), .stall_i(stall1), .redirect_i(redir1), .redirect_pc_i(rpc1),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_ack_i(ack1), .imem_data_i(data1),
    .instr_valid_o(valid1), .instr_o(instr1), .pc_o(pc1)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk_i(clk), .rst_i(rst2), .stall_i(stall2), .redirect_i(redir2), .redirect_pc_i(rpc2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_data_i(data2),
    .instr_valid_o(valid2), .instr_o(instr2), .pc_o(pc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check no push into a full queue, advance, then drive the memory model.
  task automatic cyc();
    logic f1, p1;
    #1;
    chk("no_push_full1", {31'b0, dut1.push_en && (dut1.count_q == 2)}, 32'd0);
    chk("no_push_full2", {31'b0, dut2.push_en && (dut2.count_q == 2)}, 32'd0);
    f1 = req1 && ack1;
    p1 = req1;
    @(posedge clk);
    #1;
    if (req1 && p1 && !f1) wcnt++;
    else wcnt = 0;
    ack1  = req1 && (wcnt >= wait_n);
    data1 = addr1 ^ C;
    ack2  = req2;
    data2 = addr2 ^ C;
  endtask

  task automatic reset1(input int w);
    stall1 = 1'b0;
    redir1 = 1'b0;
    rpc1   = '0;
    wait_n = w;
    rst1   = 1'b1;
    cyc();
    cyc();
    rst1 = 1'b0;
  endtask

  initial begin
    // Test 1: reset values, zero-wait streaming
    reset1(0);
    chk("rst_req", {31'b0, req1}, 32'd0);
    chk("rst_addr", addr1, 32'h0);
    chk("rst_valid", {31'b0, valid1}, 32'd0);
    chk("rst_instr", instr1, 32'h0000_0013);
    chk("rst_pc", pc1, 32'h0);
    cyc();
    chk("t1_c1_req", {31'b0, req1}, 32'd1);
    chk("t1_c1_addr", addr1, 32'h0);
    chk("t1_c1_valid", {31'b0, valid1}, 32'd0);
    for (int k = 2; k < 8; k++) begin
      cyc();
      chk("t1_valid", {31'b0, valid1}, 32'd1);
      chk("t1_pc", pc1, 32'(4 * (k - 2)));
      chk("t1_instr", instr1, 32'(4 * (k - 2)) ^ C);
      chk("t1_addr", addr1, 32'(4 * (k - 1)));
    end

    // Test 2: three wait cycles per request
    reset1(3);
    for (int k = 1; k <= 12; k++) begin
      logic v;
      cyc();
      v = (k >= 5) && ((k - 1) % 4 == 0);
      chk("t2_req", {31'b0, req1}, 32'd1);
      chk("t2_addr", addr1, 32'(4 * ((k - 1) / 4)));
      chk("t2_valid", {31'b0, valid1}, {31'b0, v});
      if (v) begin
        chk("t2_pc", pc1, 32'(4 * ((k - 5) / 4)));
        chk("t2_instr", instr1, 32'(4 * ((k - 5) / 4)) ^ C);
      end
    end

    // Test 3: stall for 5 cycles, queue fills, order preserved on release
    reset1(0);
    cyc();
    cyc();
    stall1 = 1'b1;
    chk("t3_c2_pc", pc1, 32'h0);
    chk("t3_c2_addr", addr1, 32'h4);
    for (int k = 3; k <= 6; k++) begin
      cyc();
      chk("t3_hold_valid", {31'b0, valid1}, 32'd1);
      chk("t3_hold_pc", pc1, 32'h0);
      chk("t3_hold_instr", instr1, C);
      chk("t3_hold_req", {31'b0, req1}, 32'd0);
    end
    cyc();
    stall1 = 1'b0;
    chk("t3_c7_pc", pc1, 32'h0);
    chk("t3_c7_req", {31'b0, req1}, 32'd0);
    for (int k = 8; k <= 11; k++) begin
      cyc();
      chk("t3_rel_valid", {31'b0, valid1}, 32'd1);
      chk("t3_rel_pc", pc1, 32'(4 * (k - 7)));
      chk("t3_rel_instr", instr1, 32'(4 * (k - 7)) ^ C);
    end

    // Test 4: redirect while 0x10 is pending, acked two cycles later
    reset1(0);
    for (int k = 1; k <= 4; k++) cyc();
    chk("t4_c4_addr", addr1, 32'hC);
    wait_n = 2;
    cyc();
    chk("t4_c5_addr", addr1, 32'h10);
    chk("t4_c5_pc", pc1, 32'hC);
    redir1 = 1'b1;
    rpc1   = 32'h0000_0103;
    cyc();
    redir1 = 1'b0;
    chk("t4_c6_valid", {31'b0, valid1}, 32'd0);
    chk("t4_c6_addr", addr1, 32'h10);
    cyc();
    chk("t4_c7_valid", {31'b0, valid1}, 32'd0);
    chk("t4_c7_addr", addr1, 32'h10);
    cyc();
    chk("t4_c8_req", {31'b0, req1}, 32'd1);
    chk("t4_c8_addr", addr1, 32'h100);
    chk("t4_c8_valid", {31'b0, valid1}, 32'd0);
    cyc();
    chk("t4_c9_valid", {31'b0, valid1}, 32'd0);
    cyc();
    chk("t4_c10_valid", {31'b0, valid1}, 32'd0);
    cyc();
    chk("t4_c11_valid", {31'b0, valid1}, 32'd1);
    chk("t4_c11_pc", pc1, 32'h100);
    chk("t4_c11_instr", instr1, 32'hA5A5_0100);
    chk("t4_c11_addr", addr1, 32'h104);

    // Test 5: redirect on a full stalled queue, then redirect coincident with ack
    reset1(0);
    cyc();
    cyc();
    stall1 = 1'b1;
    cyc();
    chk("t5_full_pc", pc1, 32'h0);
    chk("t5_full_req", {31'b0, req1}, 32'd0);
    redir1 = 1'b1;
    rpc1   = 32'h0000_0200;
    cyc();
    chk("t5_flush_valid", {31'b0, valid1}, 32'd0);
    chk("t5_flush_addr", addr1, 32'h200);
    chk("t5_ack_same", {31'b0, ack1}, 32'd1);
    rpc1 = 32'h0000_0300;
    cyc();
    redir1 = 1'b0;
    chk("t5_drop_valid", {31'b0, valid1}, 32'd0);
    chk("t5_tgt_req", {31'b0, req1}, 32'd1);
    chk("t5_tgt_addr", addr1, 32'h300);
    cyc();
    chk("t5_first_pc", pc1, 32'h300);
    chk("t5_first_instr", instr1, 32'hA5A5_0300);
    cyc();
    chk("t5_hold_pc", pc1, 32'h300);
    chk("t5_hold_req", {31'b0, req1}, 32'd0);
    stall1 = 1'b0;

    // Test 6: PC wrap from RESET_PC=0xFFFF_FFF8 and reset mid-request
    rst2 = 1'b1;
    cyc();
    rst2 = 1'b0;
    chk("t6_rst_addr", addr2, 32'hFFFF_FFF8);
    chk("t6_rst_req", {31'b0, req2}, 32'd0);
    cyc();
    chk("t6_c1_addr", addr2, 32'hFFFF_FFF8);
    chk("t6_c1_req", {31'b0, req2}, 32'd1);
    cyc();
    chk("t6_c2_addr", addr2, 32'hFFFF_FFFC);
    chk("t6_c2_pc", pc2, 32'hFFFF_FFF8);
    chk("t6_c2_instr", instr2, 32'h5A5A_FFF8);
    cyc();
    chk("t6_c3_addr", addr2, 32'h0);
    chk("t6_c3_pc", pc2, 32'hFFFF_FFFC);
    cyc();
    chk("t6_c4_addr", addr2, 32'h4);
    chk("t6_c4_pc", pc2, 32'h0);
    chk("t6_c4_instr", instr2, C);
    chk("t6_c4_req", {31'b0, req2}, 32'd1);
    rst2 = 1'b1;
    cyc();
    chk("t6_mid_req", {31'b0, req2}, 32'd0);
    chk("t6_mid_addr", addr2, 32'hFFFF_FFF8);
    chk("t6_mid_valid", {31'b0, valid2}, 32'd0);
    chk("t6_mid_instr", instr2, 32'h0000_0013);
    chk("t6_mid_pc", pc2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
